// File: rtl/serial_parity_receiver_pkg.sv
// Shared constants for the serial parity link: receiver FSM encoding and
// the line-level framing values common to transmitter and receiver.
package serial_parity_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Line levels of the asynchronous serial frame
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_parity_receiver_checker.sv
// Parity checkers for the serial link. The error output is high when the
// data word plus its parity bit does not carry the intended parity sense.
module EvenParityChecker #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_data,
    input  logic         i_parity,
    output logic         o_error
);
    // Even sense: total count of ones in data+parity must be even
    assign o_error = ^{i_data, i_parity};
endmodule

module OddParityChecker #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_data,
    input  logic         i_parity,
    output logic         o_error
);
    // Odd sense: total count of ones in data+parity must be odd
    assign o_error = ~(^{i_data, i_parity});
endmodule

// File: rtl/serial_parity_receiver.sv
// Asynchronous-serial receiver: start bit, `width` data bits LSB-first,
// one parity bit, one stop bit, idle-high line. Delivers every completed
// frame with parity and framing error flags and a one-cycle valid pulse.
module serial_parity_receiver
    import serial_parity_receiver_pkg::*;
#(
    parameter int width   = 8,
    parameter int divisor = 16,
    parameter int odd     = 0
) (
    input  logic             clk,
    input  logic             rst_x,
    input  logic             i_rx,
    output logic [width-1:0] o_data,
    output logic             o_valid,
    output logic             o_parity_error,
    output logic             o_framing_error,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(divisor);
    localparam int IDX_W = $clog2(width + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(divisor / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(divisor - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(width - 1);

    logic             r_rx_m;
    logic             r_rx_s;
    logic             r_rx_d;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_shift_en;
    logic             w_par_en;
    logic             w_done;
    logic [width-1:0] r_shift;
    logic [width:0]   w_cat;
    logic             r_par;
    logic             w_par_err;

    // Two-flop synchronizer plus one history flop for edge detection;
    // all reset high so leaving reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_rx_m <= LINE_IDLE;
            r_rx_s <= LINE_IDLE;
            r_rx_d <= LINE_IDLE;
        end else begin
            r_rx_m <= i_rx;
            r_rx_s <= r_rx_m;
            r_rx_d <= r_rx_s;
        end
    end

    // FSM state, bit-period counter and data bit index
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic; the counter free-runs within a state and is cleared
    // on every sample so each sample lands mid-bit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_en  = 1'b0;
        w_par_en    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (r_rx_d == LINE_IDLE && r_rx_s == START_BIT) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_rx_s == START_BIT) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt  = '0;
                    w_shift_en = 1'b1;
                    w_idx_nxt  = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_par_en    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // New bits enter at the MSB so the first (LSB) bit ends up in bit 0
    assign w_cat = {r_rx_s, r_shift};

    // Data shift register and parity bit; pure datapath, no reset needed
    always_ff @(posedge clk) begin
        if (w_shift_en) begin
            r_shift <= w_cat[width:1];
        end
        if (w_par_en) begin
            r_par <= r_rx_s;
        end
    end

    generate
        if (odd != 0) begin : g_odd
            OddParityChecker #(.W(width)) u_chk (
                .i_data   (r_shift),
                .i_parity (r_par),
                .o_error  (w_par_err)
            );
        end else begin : g_even
            EvenParityChecker #(.W(width)) u_chk (
                .i_data   (r_shift),
                .i_parity (r_par),
                .o_error  (w_par_err)
            );
        end
    endgenerate

    // Output register: frame results update on the stop sample and hold
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            o_data          <= '0;
            o_valid         <= 1'b0;
            o_parity_error  <= 1'b0;
            o_framing_error <= 1'b0;
        end else begin
            o_valid <= w_done;
            if (w_done) begin
                o_data          <= r_shift;
                o_parity_error  <= w_par_err;
                o_framing_error <= (r_rx_s != STOP_BIT);
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Randomized self-checking bench for serial_parity_receiver: an even and an
// odd instance each receive frames generated from the framing rules, and
// results are compared against a frame-level reference model.
module tb_serial_parity_receiver;

    localparam int W   = 8;
    localparam int DIV = 16;
    // drive cycle -> T0 is 2 synchronizer clocks, valid one after stop sample
    localparam int LAT = 2 + DIV / 2 + (W + 2) * DIV + 1;

    logic         clk   = 1'b0;
    logic         rst_x = 1'b0;
    logic         rx_e  = 1'b1;
    logic         rx_o  = 1'b1;
    logic [W-1:0] d_e, d_o;
    logic         v_e, v_o, pe_e, pe_o, fe_e, fe_o, b_e, b_o;

    serial_parity_receiver #(.width(W), .divisor(DIV), .odd(0)) u_even (
        .clk             (clk),
        .rst_x           (rst_x),
        .i_rx            (rx_e),
        .o_data          (d_e),
        .o_valid         (v_e),
        .o_parity_error  (pe_e),
        .o_framing_error (fe_e),
        .o_busy          (b_e)
    );

    serial_parity_receiver #(.width(W), .divisor(DIV), .odd(1)) u_odd (
        .clk             (clk),
        .rst_x           (rst_x),
        .i_rx            (rx_o),
        .o_data          (d_o),
        .o_valid         (v_o),
        .o_parity_error  (pe_o),
        .o_framing_error (fe_o),
        .o_busy          (b_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic [W-1:0] d;
        logic         pe;
        logic         fe;
    } rec_t;

    rec_t q_e[$];
    rec_t q_o[$];

    // Record every delivered frame, sampled mid-cycle
    always @(negedge clk) begin
        if (v_e) q_e.push_back('{cyc, d_e, pe_e, fe_e});
        if (v_o) q_o.push_back('{cyc, d_o, pe_o, fe_o});
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic be, input logic bo);
        rx_e = be;
        rx_o = bo;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_e = 1'b1;
        rx_o = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Transmit-side parity: bit that makes the ones count even / odd
    function automatic logic gen_par(input logic [W-1:0] d, input bit odd_sense);
        int ones;
        ones = $countones(d);
        return odd_sense ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic send_frame(input logic [W-1:0] d, input logic flip,
                              input logic stopv, output int c);
        logic pe, po;
        pe = gen_par(d, 1'b0) ^ flip;
        po = gen_par(d, 1'b1) ^ flip;
        c  = cyc;
        drive_bit(1'b0, 1'b0);
        for (int k = 0; k < W; k++) drive_bit(d[k], d[k]);
        drive_bit(pe, po);
        drive_bit(stopv, stopv);
    endtask

    // Compare both instances against the frame that was actually put on the line
    task automatic expect_frame(input string tag, input int c, input logic [W-1:0] d,
                                input logic flip, input logic stopv);
        logic pe, po;
        rec_t r;
        pe = gen_par(d, 1'b0) ^ flip;
        po = gen_par(d, 1'b1) ^ flip;
        check({tag, "_e_cnt"}, q_e.size(), 1);
        if (q_e.size() > 0) begin
            r = q_e.pop_front();
            check({tag, "_e_cyc"}, r.c, c + LAT);
            check({tag, "_e_data"}, r.d, d);
            check({tag, "_e_perr"}, r.pe, ($countones({d, pe}) % 2) != 0);
            check({tag, "_e_ferr"}, r.fe, !stopv);
        end
        check({tag, "_o_cnt"}, q_o.size(), 1);
        if (q_o.size() > 0) begin
            r = q_o.pop_front();
            check({tag, "_o_cyc"}, r.c, c + LAT);
            check({tag, "_o_data"}, r.d, d);
            check({tag, "_o_perr"}, r.pe, ($countones({d, po}) % 2) != 1);
            check({tag, "_o_ferr"}, r.fe, !stopv);
        end
        q_e.delete();
        q_o.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, {d_e, d_o}, 0);
        check({tag, "_valid"}, {v_e, v_o}, 0);
        check({tag, "_perr"}, {pe_e, pe_o}, 0);
        check({tag, "_ferr"}, {fe_e, fe_o}, 0);
        check({tag, "_busy"}, {b_e, b_o}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        logic [W-1:0] dv;
        logic fl, st;
        logic [W-1:0] dir_vals [3];
        dir_vals = '{8'h00, 8'h11, 8'h08};

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        rst_x = 1'b1;
        idle(5);

        // Directed clean frames
        foreach (dir_vals[i]) begin
            send_frame(dir_vals[i], 1'b0, 1'b1, c);
            expect_frame("dir", c, dir_vals[i], 1'b0, 1'b1);
            check("dir_busy_end", {b_e, b_o}, 0);
            idle(4);
        end

        // Full value sweep with random idle gaps (including none)
        for (int v = 0; v < 256; v++) begin
            send_frame(W'(v), 1'b0, 1'b1, c);
            expect_frame("sweep", c, W'(v), 1'b0, 1'b1);
            idle($urandom_range(0, 3));
        end

        // Inverted parity bit
        idle(4);
        send_frame(8'hA5, 1'b1, 1'b1, c);
        expect_frame("perr", c, 8'hA5, 1'b1, 1'b1);

        // Stop bit low then a held-low break: exactly one delivery
        idle(4);
        send_frame(8'h3C, 1'b0, 1'b0, c);
        rx_e = 1'b0;
        rx_o = 1'b0;
        repeat (400) @(negedge clk);
        expect_frame("brk", c, 8'h3C, 1'b0, 1'b0);
        idle(20);
        check("brk_rearm_cnt", q_e.size() + q_o.size(), 0);
        send_frame(8'h96, 1'b0, 1'b1, c);
        expect_frame("brk_after", c, 8'h96, 1'b0, 1'b1);

        // Short low glitch: false start, no delivery
        idle(10);
        c = cyc;
        rx_e = 1'b0;
        rx_o = 1'b0;
        repeat (4) @(negedge clk);
        rx_e = 1'b1;
        rx_o = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_hi", {b_e, b_o}, 2'b11);
        repeat (20) @(negedge clk);
        check("glitch_busy_lo", {b_e, b_o}, 0);
        repeat (200) @(negedge clk);
        check("glitch_cnt", q_e.size() + q_o.size(), 0);

        // Reset in the middle of data bit 3, then a clean frame
        dv = 8'h5A;
        drive_bit(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive_bit(dv[k], dv[k]);
        rx_e = dv[3];
        rx_o = dv[3];
        repeat (DIV / 2) @(negedge clk);
        rst_x = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_rst");
        rx_e = 1'b1;
        rx_o = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("mid_rst_hold");
        rst_x = 1'b1;
        idle(300);
        check("mid_rst_cnt", q_e.size() + q_o.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b1, c);
        expect_frame("post_rst", c, 8'h5A, 1'b0, 1'b1);

        // Random frames with random parity and stop errors
        for (int n = 0; n < 30; n++) begin
            dv = W'($urandom);
            fl = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) != 0);
            send_frame(dv, fl, st, c);
            expect_frame("rand", c, dv, fl, st);
            idle($urandom_range(4, 8));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
